// File: rtl/div_sequencer.sv
// div_sequencer: drives the multi-cycle divider for DIV/DIVU/REM/REMU, returns one
// writeback pulse per request and caches the quotient/remainder pair for the partner op.
module div_sequencer #(
  parameter int CACHE_EN = 1,
  parameter int RD_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic            resp_valid,
  output logic [31:0]     resp_result,
  output logic [RD_W-1:0] resp_rd,
  output logic            div_start,
  output logic [2:0]      div_op,
  output logic [31:0]     div_dividend,
  output logic [31:0]     div_divisor,
  input  logic [31:0]     div_result,
  input  logic            div_busy,
  input  logic            div_finished
);
  typedef enum logic [2:0] {S_IDLE, S_HIT, S_ISSUE, S_WAIT, S_PAIR, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [RD_W-1:0] rd_q;
  logic [31:0]     res_q;
  logic            c_valid, c_uns;
  logic [31:0]     c_rs1, c_rs2, c_q, c_r;
  logic            accept, hit;

  // The divider keeps no reset, so a divide left running must drain before new work.
  assign req_ready = (state == S_IDLE) && !div_busy && !div_finished && !flush;
  assign accept    = req_valid && req_ready;
  assign hit       = (CACHE_EN != 0) && c_valid && (req_rs1 == c_rs1) &&
                     (req_rs2 == c_rs2) && (req_op[0] == c_uns);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    div_start   = 1'b0;
    resp_valid  = 1'b0;
    resp_result = '0;
    resp_rd     = '0;
    case (state)
      S_IDLE:  if (accept) state_nxt = hit ? S_HIT : S_ISSUE;
      S_HIT: begin
        resp_valid  = 1'b1;
        resp_result = div_op[1] ? c_r : c_q;
        resp_rd     = rd_q;
        state_nxt   = S_IDLE;
      end
      S_ISSUE: begin
        div_start = 1'b1;
        state_nxt = flush ? S_DRAIN : S_WAIT;
      end
      // A flush landing on the finish pulse has nothing left to drain.
      S_WAIT: begin
        if (div_finished) state_nxt = flush ? S_IDLE : S_PAIR;
        else if (flush)   state_nxt = S_DRAIN;
      end
      S_PAIR: begin
        resp_valid  = 1'b1;
        resp_result = res_q;
        resp_rd     = rd_q;
        state_nxt   = S_IDLE;
      end
      S_DRAIN: if (div_finished) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_op       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      c_valid      <= 1'b0;
      c_uns        <= 1'b0;
      c_rs1        <= '0;
      c_rs2        <= '0;
      c_q          <= '0;
      c_r          <= '0;
    end else begin
      if (accept) begin
        div_op       <= req_op;
        div_dividend <= req_rs1;
        div_divisor  <= req_rs2;
        rd_q         <= req_rd;
      end
      // Requested half captured, then flip div_op so PAIR reads the partner half.
      if (state == S_WAIT && div_finished && !flush) begin
        res_q  <= div_result;
        div_op <= div_op ^ 3'b010;
      end
      if (state == S_PAIR) begin
        c_valid <= 1'b1;
        c_rs1   <= div_dividend;
        c_rs2   <= div_divisor;
        c_uns   <= div_op[0];
        c_q     <= div_op[1] ? res_q : div_result;
        c_r     <= div_op[1] ? div_result : res_q;
      end
    end
  end
endmodule
